// File: rtl/blast_map_writer.sv
// blast_map_writer: walks a detonation outward in four directions over the
// tile map (port A of the map RAM), clearing bricks, stopping at walls/bombs,
// and reporting every covered tile.
module blast_map_writer #(
    parameter int NUM_ROW       = 11,
    parameter int NUM_COL       = 19,
    parameter int MAP_MEM_WIDTH = 2,
    parameter int RANGE_W       = 3,
    localparam int ROW_W        = $clog2(NUM_ROW),
    localparam int COL_W        = $clog2(NUM_COL),
    localparam int ADDR_WIDTH   = $clog2(NUM_ROW*NUM_COL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ROW_W-1:0]         req_row,
    input  logic [COL_W-1:0]         req_col,
    input  logic [RANGE_W-1:0]       req_range,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [MAP_MEM_WIDTH-1:0] mem_rd_data,
    output logic                     mem_we,
    output logic [MAP_MEM_WIDTH-1:0] mem_wr_data,
    output logic                     blast_valid,
    output logic [ROW_W-1:0]         blast_row,
    output logic [COL_W-1:0]         blast_col,
    output logic                     blast_is_bomb,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               bricks_destroyed
);
    // Wide enough that r-k / c+k never wrap into the interior window.
    localparam int SW = ((ROW_W > COL_W) ? ROW_W : COL_W) + RANGE_W + 2;
    localparam int KW = RANGE_W + 1;

    localparam logic [MAP_MEM_WIDTH-1:0] T_EMPTY = MAP_MEM_WIDTH'(0);
    localparam logic [MAP_MEM_WIDTH-1:0] T_WALL  = MAP_MEM_WIDTH'(1);
    localparam logic [MAP_MEM_WIDTH-1:0] T_BRICK = MAP_MEM_WIDTH'(2);
    localparam logic [MAP_MEM_WIDTH-1:0] T_BOMB  = MAP_MEM_WIDTH'(3);

    localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_CENTER, S_STEP, S_RD, S_EVAL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d, tgt_row_q, tgt_row_d;
    logic [COL_W-1:0]   col_q, col_d, tgt_col_q, tgt_col_d;
    logic [RANGE_W-1:0] range_q, range_d;
    logic [1:0]         dir_q, dir_d;
    logic [KW-1:0]      k_q, k_d;
    logic [7:0]         bricks_q, bricks_d;

    logic [SW-1:0]      tr_w, tc_w;
    logic               tgt_in, req_in, end_dir, addr_en;
    logic [ROW_W-1:0]   ar;
    logic [COL_W-1:0]   ac;

    // Candidate target for the current direction/step and its interior test.
    always_comb begin
        tr_w = SW'(row_q);
        tc_w = SW'(col_q);
        case (dir_q)
            D_UP:    tr_w = SW'(row_q) - SW'(k_q);
            D_DOWN:  tr_w = SW'(row_q) + SW'(k_q);
            D_LEFT:  tc_w = SW'(col_q) - SW'(k_q);
            default: tc_w = SW'(col_q) + SW'(k_q);
        endcase
        tgt_in = (tr_w >= SW'(1)) && (tr_w <= SW'(NUM_ROW-2)) &&
                 (tc_w >= SW'(1)) && (tc_w <= SW'(NUM_COL-2));
        req_in = (req_row >= ROW_W'(1)) && (req_row <= ROW_W'(NUM_ROW-2)) &&
                 (req_col >= COL_W'(1)) && (req_col <= COL_W'(NUM_COL-2));
    end

    // Next-state and output decode for the blast walker.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        range_d       = range_q;
        dir_d         = dir_q;
        k_d           = k_q;
        tgt_row_d     = tgt_row_q;
        tgt_col_d     = tgt_col_q;
        bricks_d      = bricks_q;
        end_dir       = 1'b0;
        addr_en       = 1'b0;
        ar            = '0;
        ac            = '0;
        mem_we        = 1'b0;
        blast_valid   = 1'b0;
        blast_is_bomb = 1'b0;
        blast_row     = '0;
        blast_col     = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    row_d   = req_row;
                    col_d   = req_col;
                    range_d = req_range;
                    state_d = req_in ? S_CENTER : S_DONE;
                end
            end
            S_CENTER: begin
                addr_en     = 1'b1;
                ar          = row_q;
                ac          = col_q;
                mem_we      = 1'b1;
                blast_valid = 1'b1;
                blast_row   = row_q;
                blast_col   = col_q;
                dir_d       = D_UP;
                k_d         = KW'(1);
                state_d     = S_STEP;
            end
            S_STEP: begin
                if ((k_q > {1'b0, range_q}) || !tgt_in) begin
                    end_dir = 1'b1;
                end else begin
                    tgt_row_d = tr_w[ROW_W-1:0];
                    tgt_col_d = tc_w[COL_W-1:0];
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                addr_en = 1'b1;
                ar      = tgt_row_q;
                ac      = tgt_col_q;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                addr_en   = 1'b1;
                ar        = tgt_row_q;
                ac        = tgt_col_q;
                blast_row = tgt_row_q;
                blast_col = tgt_col_q;
                case (mem_rd_data)
                    T_EMPTY: begin
                        blast_valid = 1'b1;
                        k_d         = k_q + KW'(1);
                        state_d     = S_STEP;
                    end
                    T_BRICK: begin
                        mem_we      = 1'b1;
                        blast_valid = 1'b1;
                        if (bricks_q != 8'hFF) bricks_d = bricks_q + 8'd1;
                        end_dir     = 1'b1;
                    end
                    T_BOMB: begin
                        blast_valid   = 1'b1;
                        blast_is_bomb = 1'b1;
                        end_dir       = 1'b1;
                    end
                    default: end_dir = 1'b1;  // WALL
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (end_dir) begin
            if (dir_q == D_RIGHT) begin
                state_d = S_DONE;
            end else begin
                dir_d   = dir_q + 2'd1;
                k_d     = KW'(1);
                state_d = S_STEP;
            end
        end
    end

    assign mem_addr = addr_en ? (ADDR_WIDTH'(ar) * ADDR_WIDTH'(NUM_COL) + ADDR_WIDTH'(ac))
                              : '0;
    assign mem_wr_data      = T_EMPTY;
    assign req_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign bricks_destroyed = bricks_q;

    // State and datapath registers; reset drops straight back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            range_q   <= '0;
            dir_q     <= D_UP;
            k_q       <= '0;
            tgt_row_q <= '0;
            tgt_col_q <= '0;
            bricks_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            range_q   <= range_d;
            dir_q     <= dir_d;
            k_q       <= k_d;
            tgt_row_q <= tgt_row_d;
            tgt_col_q <= tgt_col_d;
            bricks_q  <= bricks_d;
        end
    end
endmodule

// File: tb/tb_blast_map_writer.sv
// Scoreboard bench for blast_map_writer with a behavioural map RAM.
module tb_blast_map_writer;
    localparam int NR = 11, NC = 19, RW = 4, CW = 5, AW = 8, NT = NR*NC;

    logic          clk = 1'b0, rst = 1'b1;
    logic          req_valid = 1'b0, req_ready;
    logic [RW-1:0] req_row = '0;
    logic [CW-1:0] req_col = '0;
    logic [2:0]    req_range = '0;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_rd_data, mem_wr_data;
    logic          mem_we, blast_valid, blast_is_bomb, busy, done;
    logic [RW-1:0] blast_row;
    logic [CW-1:0] blast_col;
    logic [7:0]    bricks_destroyed;

    blast_map_writer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_range(req_range),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_we(mem_we),
        .mem_wr_data(mem_wr_data), .blast_valid(blast_valid), .blast_row(blast_row),
        .blast_col(blast_col), .blast_is_bomb(blast_is_bomb), .busy(busy),
        .done(done), .bricks_destroyed(bricks_destroyed)
    );

    always #5 clk = ~clk;

    // Map RAM port A model with a bench-side loader.
    logic [1:0]    mem [NT];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [1:0]    ld_data = '0;
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    int checks = 0, errors = 0, done_cnt = 0;
    bit sb_en = 1'b1;
    int exp_b[$];
    int exp_w[$];
    int acc_q[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bcode(input int r, input int c, input int b);
        return r*1000 + c*10 + b;
    endfunction

    // Monitor: compare every blast pulse and write against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && mem_addr != '0) acc_q.push_back(int'(mem_addr));
            if (done) done_cnt++;
            if (sb_en && blast_valid) begin
                if (exp_b.size() == 0)
                    check("unexpected_blast", bcode(blast_row, blast_col, blast_is_bomb), -1);
                else
                    check("blast", bcode(blast_row, blast_col, blast_is_bomb), exp_b.pop_front());
            end
            if (sb_en && mem_we) begin
                check("wr_data", int'(mem_wr_data), 0);
                if (exp_w.size() == 0) check("unexpected_write", int'(mem_addr), -1);
                else check("write_addr", int'(mem_addr), exp_w.pop_front());
            end
        end
    end

    task automatic set_tile(input int r, input int c, input logic [1:0] v);
        ld_en = 1'b1; ld_addr = AW'(r*NC + c); ld_data = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic init_map();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                set_tile(r, c, (r == 0 || c == 0 || r == NR-1 || c == NC-1) ? 2'd1 : 2'd0);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 300) begin @(posedge clk); #1; n++; end
    endtask

    // Issue one request and check the cycle in which done appears.
    task automatic run_req(input int r, input int c, input int rng, input int exp_cyc, input string nm);
        int n;
        acc_q.delete();
        check({nm, "_ready"}, int'(req_ready), 1);
        req_row = RW'(r); req_col = CW'(c); req_range = 3'(rng); req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(n);
        check({nm, "_done_cycle"}, n, exp_cyc);
        @(posedge clk); #1;
        check({nm, "_blasts_left"}, exp_b.size(), 0);
        check({nm, "_writes_left"}, exp_w.size(), 0);
    endtask

    task automatic pb(input int r, input int c, input int b);
        exp_b.push_back(bcode(r, c, b));
    endtask

    initial begin
        int n, bad, dc;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_blast", int'(blast_valid), 0);
        check("rst_bomb", int'(blast_is_bomb), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_bricks", int'(bricks_destroyed), 0);
        rst = 1'b0;

        // 1: open field, range 2
        init_map();
        set_tile(5, 5, 2'd3);
        pb(5,5,0); pb(4,5,0); pb(3,5,0); pb(6,5,0); pb(7,5,0);
        pb(5,4,0); pb(5,3,0); pb(5,6,0); pb(5,7,0);
        exp_w.push_back(100);
        run_req(5, 5, 2, 30, "open");
        check("open_centre_cleared", int'(mem[100]), 0);

        // 2: brick to the right, wall above
        init_map();
        set_tile(5, 6, 2'd2); set_tile(4, 5, 2'd1);
        pb(5,5,0); pb(6,5,0); pb(7,5,0); pb(8,5,0);
        pb(5,4,0); pb(5,3,0); pb(5,2,0); pb(5,6,0);
        exp_w.push_back(100); exp_w.push_back(101);
        run_req(5, 5, 3, 28, "brick");
        check("brick_count", int'(bricks_destroyed), 1);
        check("brick_cleared", int'(mem[101]), 0);
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i] == 62 || acc_q[i] == 102) bad++;
        check("brick_no_access_beyond", bad, 0);

        // 3: corner-adjacent centre
        init_map();
        pb(1,1,0); pb(2,1,0); pb(3,1,0); pb(4,1,0); pb(5,1,0);
        pb(1,2,0); pb(1,3,0); pb(1,4,0); pb(1,5,0);
        exp_w.push_back(20);
        run_req(1, 1, 4, 30, "corner");
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i] < NC || acc_q[i] % NC == 0) bad++;
        check("corner_border_access", bad, 0);

        // 4: bomb to the left
        init_map();
        set_tile(5, 3, 2'd3);
        pb(5,5,0); pb(4,5,0); pb(3,5,0); pb(2,5,0); pb(6,5,0); pb(7,5,0); pb(8,5,0);
        pb(5,4,0); pb(5,3,1); pb(5,6,0); pb(5,7,0); pb(5,8,0);
        exp_w.push_back(100);
        run_req(5, 5, 3, 38, "bomb");
        check("bomb_kept", int'(mem[98]), 3);
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i] == 97) bad++;
        check("bomb_no_access_beyond", bad, 0);

        // 5: border centre, then range 0
        run_req(0, 4, 3, 1, "border");
        pb(5,5,0); exp_w.push_back(100);
        run_req(5, 5, 0, 6, "range0");

        // 6: reset mid-request
        init_map();
        set_tile(5, 5, 2'd3);
        sb_en = 1'b0;
        req_row = 4'd5; req_col = 5'd5; req_range = 3'd2; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        dc = done_cnt;
        check("mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_ready", int'(req_ready), 1);
        check("rst_mid_bricks", int'(bricks_destroyed), 0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt, dc);
        check("rst_mid_write_kept", int'(mem[100]), 0);
        check("rst_after_ready", int'(req_ready), 1);
        sb_en = 1'b1;

        // 7: request held high while busy
        pb(5,5,0); pb(5,5,0);
        exp_w.push_back(100); exp_w.push_back(100);
        req_row = 4'd5; req_col = 5'd5; req_range = 3'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        check("held_first_done", n, 6);
        @(posedge clk); #1;
        check("held_ready_after_done", int'(req_ready), 1);
        @(posedge clk); #1;
        check("held_accepted", int'(busy), 1);
        req_valid = 1'b0;
        wait_done(n);
        check("held_second_done", n, 6);
        @(posedge clk); #1;
        check("held_blasts_left", exp_b.size(), 0);
        check("held_writes_left", exp_w.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/blast_map_writer.md
# blast_map_writer

Writes explosion results into the tile map RAM that the obstacle checker reads. It accepts one detonation request at a time, given as a centre tile and a range. For each of the four directions it walks the map by read-modify-write: it clears destructible bricks to EMPTY, stops at hard walls, and reports every tile the blast covers. It owns port A (read/write) of the dual-port map RAM; the obstacle checker owns read-only port B.

## Interface
Parameters:
- NUM_ROW, 11, map rows; row 0 and row NUM_ROW-1 are border walls
- NUM_COL, 19, map columns; col 0 and col NUM_COL-1 are border walls
- MAP_MEM_WIDTH, 2, tile code width; codes: 00 EMPTY, 01 WALL, 10 BRICK, 11 BOMB
- RANGE_W, 3, width of the range field
- Derived: ROW_W = $clog2(NUM_ROW), COL_W = $clog2(NUM_COL), ADDR_WIDTH = $clog2(NUM_ROW*NUM_COL)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  detonation request
- req_ready  out  1  high only in IDLE
- req_row  in  ROW_W  centre tile row
- req_col  in  COL_W  centre tile column
- req_range  in  RANGE_W  blast length in tiles per direction
- mem_addr  out  ADDR_WIDTH  port A address, equal to row*NUM_COL+col
- mem_rd_data  in  MAP_MEM_WIDTH  port A read data; synchronous, valid 1 cycle after the address
- mem_we  out  1  port A write enable
- mem_wr_data  out  MAP_MEM_WIDTH  port A write data; always EMPTY
- blast_valid  out  1  one pulse per tile covered by the blast
- blast_row, blast_col  out  ROW_W/COL_W  covered tile
- blast_is_bomb  out  1  the covered tile holds a BOMB; used by the chain logic
- busy  out  1  high whenever not in IDLE
- done  out  1  1-cycle pulse when a request completes
- bricks_destroyed  out  8  cumulative count since reset, saturates at 255

## Operation
- States: IDLE, CENTER, STEP, RD, EVAL, DONE.
- IDLE:
  - A request is accepted when req_valid && req_ready; req_row, req_col and req_range are latched.
  - If the centre tile is in the interior (rows 1..NUM_ROW-2, cols 1..NUM_COL-2), go to CENTER. Otherwise go to DONE with no writes and no blasts.
- CENTER (1 cycle):
  - Write EMPTY to the centre tile; this clears the bomb.
  - blast_valid=1 at the centre, blast_is_bomb=0.
  - Set dir=UP and k=1, then go to STEP.
- Direction order is UP(0), DOWN(1), LEFT(2), RIGHT(3). Targets: UP (r-k, c), DOWN (r+k, c), LEFT (r, c-k), RIGHT (r, c+k).
- STEP (1 cycle): compute the target tile using arithmetic wide enough to avoid wrap.
  - If k > range, or the target is outside the interior: the direction ends. Go to DONE if dir==RIGHT; otherwise increment dir, set k=1 and stay in STEP.
  - Otherwise go to RD. No memory access is made for out-of-bounds targets.
- RD (1 cycle): mem_addr = target. Go to EVAL.
- EVAL (1 cycle): mem_addr is held and mem_rd_data holds the target tile.
  - EMPTY: blast_valid=1, then k++ and go to STEP.
  - BRICK: mem_we=1 (EMPTY), blast_valid=1, bricks_destroyed++, then end the direction.
  - BOMB: blast_valid=1 with blast_is_bomb=1, no write, then end the direction.
  - WALL: no write, no blast, then end the direction.
  - Ending the direction in EVAL goes to DONE if dir==RIGHT; otherwise increment dir, set k=1 and go to STEP.
- DONE (1 cycle): done=1, then go to IDLE.
- req_valid while busy is ignored; the requester holds it until req_ready is high.
- mem_we, blast_valid and blast_is_bomb are 0 in every state not listed above as asserting them.
- mem_addr is 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, req_ready=1, busy=0, done=0, mem_we=0, blast_valid=0, blast_is_bomb=0, mem_addr=0, bricks_destroyed=0.
- Reset mid-operation: return to IDLE at the next edge with no done pulse. Writes already issued stay in memory.
- Cycle counting: acceptance happens in cycle 0 and CENTER occupies cycle 1.
- Cost per reached tile: 3 cycles (STEP, RD, EVAL).
- Cost of ending a direction: 1 cycle when it ends in STEP; 0 extra cycles when it ends in EVAL.
- Open field, interior centre, range R: done in cycle 2 + 4(3R+1), i.e. R=2 gives done in cycle 30.
- Range 0: CENTER, 4 STEP cycles, DONE; done in cycle 6.
- Out-of-interior centre: done in cycle 1.
- req_ready returns high in the cycle after done, so the earliest next acceptance is done_cycle+1.
- Port B sees port A writes per the RAM's write-first setting; no arbitration is needed.

## Test plan
- Empty interior map, request (5,5) range 2 → 9 blast pulses: (5,5), then (4,5), (3,5), (6,5), (7,5), (5,4), (5,3), (5,6), (5,7) in that order. One write at addr 100. done in cycle 30.
- BRICK at (5,6), WALL at (4,5), request (5,5) range 3 → RIGHT writes EMPTY to addr 101 and stops; UP emits no blast; bricks_destroyed=1. No access beyond either tile.
- Request (1,1) range 4 → UP and LEFT make no RD cycles. DOWN covers rows 2..5 and RIGHT covers cols 2..5. mem_addr never targets row 0 or col 0.
- BOMB at (5,3), request (5,5) range 3 → blast at (5,3) with blast_is_bomb=1, no write there, LEFT stops.
- Request (0,4) → done in cycle 1, no mem_we. A range-0 request at (5,5) → done in cycle 6 with one blast pulse.
- rst asserted in the middle of a request → IDLE next cycle, no done; req_ready=1 after rst deasserts; a req_valid held high during busy is accepted the cycle after done.
